store_narrower: RTL and testbench



---
 rtl/store_narrower_pkg.sv | 11 +
 rtl/store_narrower_if.sv | 23 ++
 rtl/store_fifo.sv | 41 ++++
 rtl/store_narrower.sv | 57 +++++
 tb/tb_store_narrower.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/store_narrower_pkg.sv
// store_narrower_pkg: size encodings, store-buffer entry layout and drain states.
package store_narrower_pkg;
  localparam int ST_AW = 32;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} st_size_t;
  typedef struct packed {
    logic [ST_AW-1:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
  } store_entry_t;
  typedef enum logic {IDLE, DRAIN} drain_state_t;
endpackage

// File: rtl/store_narrower_if.sv
// store_narrower_if: store request side and memory write side of the store path.
interface store_narrower_if #(parameter int AW = 32);
  logic st_valid;
  logic st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0] st_data;
  logic [1:0] st_size;
  logic mem_req;
  logic mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_be;
  logic misalign;
  logic busy;
  modport slave (
    input st_valid, st_addr, st_data, st_size, mem_gnt,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be, misalign, busy
  );
  modport master (
    output st_valid, st_addr, st_data, st_size, mem_gnt,
    input st_ready, mem_req, mem_addr, mem_wdata, mem_be, misalign, busy
  );
endinterface

// File: rtl/store_fifo.sv
// store_fifo: power-of-two circular buffer with occupancy count.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 68,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/store_narrower.sv
// store_narrower: narrows and lane-places register stores, buffers them and drains to memory.
module store_narrower
  import store_narrower_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = 32
) (
  input logic clk,
  input logic rst_n,
  store_narrower_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  st_size_t sz;
  store_entry_t din, head;
  drain_state_t state, nxt;
  logic accept, bad, push, pop, full, empty;
  logic [CW-1:0] count;
  always_comb begin
    sz = st_size_t'(bus.st_size);
    accept = bus.st_valid && !full;
    bad = sz == SZ_ILL || (sz == SZ_HALF && bus.st_addr[0]) || (sz == SZ_WORD && |bus.st_addr[1:0]);
    push = accept && !bad;
    pop = bus.mem_req && bus.mem_gnt;
    din.addr = {bus.st_addr[AW-1:2], 2'b00};
    din.wdata = sz == SZ_BYTE ? {4{bus.st_data[7:0]}} : sz == SZ_HALF ? {2{bus.st_data[15:0]}} : bus.st_data;
    din.be = sz == SZ_BYTE ? 4'b0001 << bus.st_addr[1:0] : sz == SZ_HALF ? (bus.st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    nxt = state == IDLE ? (push ? DRAIN : IDLE) : (pop && count == CW'(1) && !push ? IDLE : DRAIN);
  end
  store_fifo #(.DEPTH(DEPTH), .W($bits(store_entry_t))) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.st_ready = !full;
  assign bus.busy = !empty;
  // Head fields are masked while idle so drained entries never linger on the bus.
  assign bus.mem_addr = bus.busy ? head.addr : '0;
  assign bus.mem_wdata = bus.busy ? head.wdata : '0;
  assign bus.mem_be = bus.busy ? head.be : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.mem_req <= 1'b0;
      bus.misalign <= 1'b0;
    end else begin
      state <= nxt;
      bus.mem_req <= nxt == DRAIN;
      bus.misalign <= accept && bad;
    end
  end
endmodule

// File: tb/tb_store_narrower.sv
// tb_store_narrower: scoreboard bench for the buffered store narrower.
module tb_store_narrower;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int passed = 0;
  logic [67:0] q[$];
  logic exp_mis = 0;
  store_narrower_if #(.AW(32)) bus();
  store_narrower #(.DEPTH(2), .AW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.st_valid = v;
    bus.st_addr = a;
    bus.st_data = d;
    bus.st_size = s;
  endtask

  function automatic logic [67:0] ref_entry(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    logic [31:0] w;
    logic [3:0] be;
    for (int i = 0; i < 4; i++) begin
      w[8*i+:8] = s == 2'd0 ? d[7:0] : s == 2'd1 ? d[8*(i%2)+:8] : d[8*i+:8];
      be[i] = s == 2'd0 ? (i == int'(a[1:0])) : s == 2'd1 ? ((i / 2) == int'(a[1])) : 1'b1;
    end
    return {a[31:2], 2'b00, w, be};
  endfunction

  function automatic logic is_bad(input logic [31:0] a, input logic [1:0] s);
    return s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    exp_mis = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      logic acc;
      acc = bus.st_valid && q.size() < 2;
      exp_mis = acc && is_bad(bus.st_addr, bus.st_size);
      if (bus.mem_gnt && q.size() != 0) void'(q.pop_front());
      if (acc && !is_bad(bus.st_addr, bus.st_size)) q.push_back(ref_entry(bus.st_addr, bus.st_data, bus.st_size));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", bus.mem_req, 0);
      chk("rst_ready", bus.st_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_mis", bus.misalign, 0);
    end else begin
      chk("sb_req", bus.mem_req, q.size() != 0);
      chk("sb_busy", bus.busy, q.size() != 0);
      chk("sb_ready", bus.st_ready, q.size() < 2);
      chk("sb_mis", bus.misalign, exp_mis);
      if (q.size() != 0) chk("sb_head", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, q[0]);
    end
  end

  initial begin
    bus.mem_gnt = 0;
    drive(0, 0, 0, 0);
    #1;
    chk("reset_addr", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, 0);
    chk("reset_ready", bus.st_ready, 1);
    step;
    step;
    rst_n = 1;
    bus.mem_gnt = 1;
    drive(1, 32'h1003, 32'h123456AB, 2'b00);
    step;
    drive(0, 0, 0, 0);
    chk("sb_req1", bus.mem_req, 1);
    chk("sb_word", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, {32'h1000, 32'hABABABAB, 4'b1000});
    step;
    chk("sb_done", bus.busy, 0);
    bus.mem_gnt = 0;
    drive(1, 32'h2002, 32'hFFFF8765, 2'b01);
    step;
    drive(1, 32'h2004, 32'hDEADBEEF, 2'b10);
    step;
    drive(0, 0, 0, 0);
    chk("full_ready", bus.st_ready, 0);
    chk("sh_head", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, {32'h2000, 32'h87658765, 4'b1100});
    step;
    chk("sh_hold", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, {32'h2000, 32'h87658765, 4'b1100});
    bus.mem_gnt = 1;
    step;
    chk("sw_head", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, {32'h2004, 32'hDEADBEEF, 4'b1111});
    chk("pop_ready", bus.st_ready, 1);
    step;
    bus.mem_gnt = 0;
    chk("drained", bus.busy, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive(1, 32'h3002, 32'h11223344, 2'b10);
      else if (k == 1) drive(1, 32'h3001, 32'h55667788, 2'b01);
      else drive(1, 32'h3000, 32'h99AABBCC, 2'b11);
      step;
      drive(0, 0, 0, 0);
      chk("mis_pulse", bus.misalign, 1);
      chk("mis_noreq", bus.mem_req, 0);
      chk("mis_busy", bus.busy, 0);
      step;
      chk("mis_low", bus.misalign, 0);
    end
    drive(1, 32'h4000, 32'h11111111, 2'b10);
    step;
    drive(1, 32'h4001, 32'h00000022, 2'b00);
    step;
    drive(1, 32'h4006, 32'h00003333, 2'b01);
    bus.mem_gnt = 1;
    step;
    bus.mem_gnt = 0;
    chk("full_skip_head", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, {32'h4000, 32'h22222222, 4'b0010});
    step;
    drive(0, 0, 0, 0);
    chk("late_accept", bus.st_ready, 0);
    bus.mem_gnt = 1;
    step;
    step;
    bus.mem_gnt = 0;
    chk("order_done", bus.busy, 0);
    drive(1, 32'h5000, 32'hCAFEF00D, 2'b10);
    step;
    drive(1, 32'h5004, 32'h0BADBEEF, 2'b10);
    step;
    drive(0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("arst_req", bus.mem_req, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.st_ready, 1);
    chk("arst_out", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, 0);
    step;
    step;
    rst_n = 1;
    step;
    step;
    chk("arst_stale", bus.mem_req, 0);
    for (int n = 0; n < 300; n++) begin
      bus.mem_gnt = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
      step;
    end
    drive(0, 0, 0, 0);
    bus.mem_gnt = 1;
    repeat (5) step;
    chk("final_drain", bus.busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
